// File: rtl/branch_pkg.sv
// Shared branch constants: B-type funct3 encodings, 2-bit counter states and
// saturating counter helpers used by the resolver and its BHT.
package branch_pkg;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  typedef struct packed {
    logic taken;
    logic mispredict;
    logic illegal;
  } res_t;

  function automatic logic [1:0] sat_inc(input logic [1:0] ctr);
    return (ctr == ST) ? ST : ctr + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] ctr);
    return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table of 2-bit saturating counters: one combinational read
// port for fetch and one read-modify-write update port for resolved branches.
module bht_2bit
  import branch_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IDX_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [1:0]       rd_ctr_o,
  input  logic             upd_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  logic [1:0] ctr_q [DEPTH];
  logic [1:0] upd_old;
  logic [1:0] upd_new;

  // Fetch sees the stored value; a same-cycle update lands only at the edge.
  assign rd_ctr_o = ctr_q[rd_idx_i];
  assign upd_old  = ctr_q[upd_idx_i];

  always_comb begin
    upd_new = upd_taken_i ? sat_inc(upd_old) : sat_dec(upd_old);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr_q[i] <= WNT;
      end
    end else if (upd_i) begin
      ctr_q[upd_idx_i] <= upd_new;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver with 2-bit BHT predictor.
// Optional feature macro: BRANCH_STATS_EN adds branch/mispredict counters.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned IDX_W     = $clog2(BHT_DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            kill,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_pred,
  input  logic            ex_valid,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_pred,
  input  logic            zflag,
  input  logic            nflag,
  input  logic            cflag,
  input  logic            vflag,
  output logic            res_valid,
  output logic            res_taken,
  output logic            mispredict,
  output logic            illegal
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  logic             accept;
  logic             cond_taken;
  logic             cond_legal;
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] ex_idx;
  logic [1:0]       if_ctr;
  logic             unused_pc;
  res_t             res_d;
  res_t             res_q;
  logic             res_valid_q;

  assign accept = ex_valid & ~stall & ~kill;
  assign if_idx = if_pc[IDX_W+1:2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign unused_pc = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0], ex_pc[XLEN-1:IDX_W+2], ex_pc[1:0]};

  // cflag is carry-out of rs1-rs2, so C=1 means rs1 >= rs2 unsigned.
  always_comb begin
    cond_taken = 1'b0;
    cond_legal = 1'b1;
    unique case (ex_funct3)
      BEQ:     cond_taken = zflag;
      BNE:     cond_taken = ~zflag;
      BLT:     cond_taken = nflag ^ vflag;
      BGE:     cond_taken = ~(nflag ^ vflag);
      BLTU:    cond_taken = ~cflag;
      BGEU:    cond_taken = cflag;
      default: cond_legal = 1'b0;
    endcase
  end

  // An illegal encoding resolves not-taken, so a taken prediction is wrong.
  always_comb begin
    res_d.taken      = cond_taken;
    res_d.mispredict = cond_legal ? (cond_taken ^ ex_pred) : ex_pred;
    res_d.illegal    = ~cond_legal;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      res_valid_q <= accept;
      if (accept) begin
        res_q <= res_d;
      end
    end
  end

  assign res_valid  = res_valid_q;
  assign res_taken  = res_q.taken;
  assign mispredict = res_valid_q & res_q.mispredict;
  assign illegal    = res_valid_q & res_q.illegal;

  bht_2bit #(
    .DEPTH (BHT_DEPTH),
    .IDX_W (IDX_W)
  ) u_bht (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .rd_idx_i    (if_idx),
    .rd_ctr_o    (if_ctr),
    .upd_i       (accept & cond_legal),
    .upd_idx_i   (ex_idx),
    .upd_taken_i (cond_taken)
  );

  assign if_pred = if_ctr[1];

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_br_q;
  logic [31:0] stat_mp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (res_valid) begin
        stat_br_q <= stat_br_q + 32'd1;
      end
      if (mispredict) begin
        stat_mp_q <= stat_mp_q + 32'd1;
      end
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: abstract reference model plus
// directed vectors with hand-computed literals.
module tb_branch_resolve_unit;

  localparam int unsigned Depth = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, kill;
  logic [31:0] if_pc;
  logic        if_pred;
  logic        ex_valid;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_pc;
  logic        ex_pred;
  logic        zflag, nflag, cflag, vflag;
  logic        res_valid, res_taken, mispredict, illegal;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  int tests = 0;
  int fails = 0;

  branch_resolve_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .kill       (kill),
    .if_pc      (if_pc),
    .if_pred    (if_pred),
    .ex_valid   (ex_valid),
    .ex_funct3  (ex_funct3),
    .ex_pc      (ex_pc),
    .ex_pred    (ex_pred),
    .zflag      (zflag),
    .nflag      (nflag),
    .cflag      (cflag),
    .vflag      (vflag),
    .res_valid  (res_valid),
    .res_taken  (res_taken),
    .mispredict (mispredict),
    .illegal    (illegal)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int   mbht [Depth];
  logic m_valid, m_taken, m_misp, m_ill;

  function automatic logic is_legal(input logic [2:0] f);
    return (f != 3'b010) && (f != 3'b011);
  endfunction

  // Direction from ALU flags: equality from Z, signed less-than from N^V,
  // unsigned less-than from borrow (C=0).
  function automatic logic exp_taken(input logic [2:0] f, input logic z, n, c, v);
    logic lt_s, lt_u;
    lt_s = n ^ v;
    lt_u = !c;
    case (f)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return lt_s;
      3'b101:  return !lt_s;
      3'b110:  return lt_u;
      3'b111:  return !lt_u;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_taken <= 1'b0;
      m_misp  <= 1'b0;
      m_ill   <= 1'b0;
      for (int i = 0; i < Depth; i++) mbht[i] <= 1;
    end else begin
      m_valid <= ex_valid && !stall && !kill;
      if (ex_valid && !stall && !kill) begin
        m_taken <= exp_taken(ex_funct3, zflag, nflag, cflag, vflag);
        m_ill   <= !is_legal(ex_funct3);
        if (is_legal(ex_funct3)) begin
          m_misp <= exp_taken(ex_funct3, zflag, nflag, cflag, vflag) != ex_pred;
          if (exp_taken(ex_funct3, zflag, nflag, cflag, vflag))
            mbht[idx_of(ex_pc)] <= (mbht[idx_of(ex_pc)] < 3) ? mbht[idx_of(ex_pc)] + 1 : 3;
          else
            mbht[idx_of(ex_pc)] <= (mbht[idx_of(ex_pc)] > 0) ? mbht[idx_of(ex_pc)] - 1 : 0;
        end else begin
          m_misp <= ex_pred;
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare();
    chk("res_valid", {31'd0, res_valid}, {31'd0, m_valid});
    chk("res_taken", {31'd0, res_taken}, {31'd0, m_taken});
    chk("mispredict", {31'd0, mispredict}, {31'd0, m_valid & m_misp});
    chk("illegal", {31'd0, illegal}, {31'd0, m_valid & m_ill});
    chk("if_pred", {31'd0, if_pred}, {31'd0, mbht[idx_of(if_pc)] >= 2});
  endtask

  // Advance one clock: compare at the falling edge, then return just after it.
  task automatic step();
    @(negedge clk);
    compare();
    #1;
  endtask

  task automatic branch(input logic [2:0] f, input logic [31:0] pc, input logic pred,
                        input logic z, input logic n, input logic c, input logic v);
    ex_valid = 1'b1; ex_funct3 = f; ex_pc = pc; ex_pred = pred;
    zflag = z; nflag = n; cflag = c; vflag = v;
    step();
  endtask

  task automatic idle();
    ex_valid = 1'b0;
    step();
  endtask

  // Flags derived from a real rs1-rs2 subtraction.
  task automatic op_branch(input string name, input logic [2:0] f, input logic [31:0] a,
                           input logic [31:0] b, input logic want);
    logic [31:0] d;
    d = a - b;
    branch(f, 32'h400, 1'b0, a == b, d[31], a >= b, (a[31] != b[31]) && (d[31] != a[31]));
    chk(name, {31'd0, res_taken}, {31'd0, want});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; kill = 1'b0; if_pc = '0; ex_valid = 1'b0;
    ex_funct3 = '0; ex_pc = '0; ex_pred = 1'b0;
    zflag = 1'b0; nflag = 1'b0; cflag = 1'b0; vflag = 1'b0;
    step();
    step();
    chk("reset_if_pred", {31'd0, if_pred}, 32'd0);
    chk("reset_res_valid", {31'd0, res_valid}, 32'd0);
    chk("reset_outputs", {28'd0, res_taken, mispredict, illegal, res_valid}, 32'd0);
    rst_n = 1'b1;

    // Sweep every BHT entry: weak not-taken reads as predict not-taken.
    for (int i = 0; i < Depth; i++) begin
      if_pc = 32'(i) << 2;
      step();
      chk("sweep_if_pred", {31'd0, if_pred}, 32'd0);
    end

    // First BEQ taken with not-taken prediction; same-cycle lookup sees old counter.
    if_pc = 32'h104;
    ex_valid = 1'b1; ex_funct3 = 3'b000; ex_pc = 32'h104; ex_pred = 1'b0;
    zflag = 1'b1; nflag = 1'b0; cflag = 1'b1; vflag = 1'b0;
    #1;
    chk("same_cycle_old", {31'd0, if_pred}, 32'd0);
    step();
    chk("beq_valid", {31'd0, res_valid}, 32'd1);
    chk("beq_taken", {31'd0, res_taken}, 32'd1);
    chk("beq_mispredict", {31'd0, mispredict}, 32'd1);
    chk("beq_bht_10", {31'd0, if_pred}, 32'd1);
    idle();
    chk("idle_valid", {31'd0, res_valid}, 32'd0);

    // Saturation at both ends on index 0.
    if_pc = 32'h200;
    repeat (4) branch(3'b000, 32'h200, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle();
    chk("sat_hi_pred", {31'd0, if_pred}, 32'd1);
    branch(3'b000, 32'h200, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    chk("sat_hi_nt1", {31'd0, if_pred}, 32'd1);
    branch(3'b000, 32'h200, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    chk("sat_hi_nt2", {31'd0, if_pred}, 32'd0);
    repeat (2) branch(3'b000, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    branch(3'b000, 32'h200, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle();
    chk("sat_lo_t1", {31'd0, if_pred}, 32'd0);
    branch(3'b000, 32'h200, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle();
    chk("sat_lo_t2", {31'd0, if_pred}, 32'd1);

    // Stall and kill block acceptance and BHT update.
    if_pc = 32'h308;
    stall = 1'b1;
    branch(3'b000, 32'h308, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("stall_no_valid", {31'd0, res_valid}, 32'd0);
    stall = 1'b0; kill = 1'b1;
    branch(3'b000, 32'h308, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("kill_no_valid", {31'd0, res_valid}, 32'd0);
    chk("kill_taken_hold", {31'd0, res_taken}, 32'd1);
    kill = 1'b0;
    idle();
    chk("stall_bht_same", {31'd0, if_pred}, 32'd0);

    // Illegal encodings: no update, mispredict follows prediction.
    if_pc = 32'h30c;
    branch(3'b010, 32'h30c, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ill_010", {29'd0, illegal, mispredict, res_taken}, 32'b110);
    branch(3'b011, 32'h30c, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("ill_011", {29'd0, illegal, mispredict, res_taken}, 32'b100);
    branch(3'b000, 32'h30c, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    idle();
    chk("ill_bht_same", {31'd0, if_pred}, 32'd1);

    // Every funct3 against all 16 flag combinations.
    for (int f = 0; f < 8; f++) begin
      for (int k = 0; k < 16; k++) begin
        logic [3:0] kk;
        logic [2:0] ff;
        kk = 4'(k);
        ff = 3'(f);
        if_pc = 32'(f * 16 + k) << 2;
        branch(ff, 32'(k * 8 + f) << 2, kk[0] ^ ff[0], kk[0], kk[3], kk[1], kk[2]);
      end
    end
    idle();

    // Direction from real operand pairs.
    op_branch("blt_neg", 3'b100, 32'hffff_ffff, 32'd1, 1'b1);
    op_branch("bltu_big", 3'b110, 32'hffff_ffff, 32'd1, 1'b0);
    op_branch("bge_eq", 3'b101, 32'd5, 32'd5, 1'b1);
    op_branch("bgeu_lt", 3'b111, 32'd1, 32'd2, 1'b0);
    op_branch("blt_ovf", 3'b100, 32'h8000_0000, 32'd1, 1'b1);
    op_branch("bne_ne", 3'b001, 32'd7, 32'd9, 1'b1);

    // Asynchronous reset while a result is in flight.
    if_pc = 32'h104;
    branch(3'b000, 32'h104, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("pre_reset_valid", {31'd0, res_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {28'd0, res_valid, res_taken, mispredict, illegal}, 32'd0);
    chk("midreset_if_pred", {31'd0, if_pred}, 32'd0);
    ex_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();

`ifdef BRANCH_STATS_EN
    chk("stats_reset_br", stat_branches, 32'd0);
    for (int i = 0; i < 10; i++) begin
      branch(3'b000, 32'h500, (i % 3 == 0 && i < 9) ? 1'b0 : 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    end
    idle();
    idle();
    chk("stats_branches", stat_branches, 32'd10);
    chk("stats_mispredicts", stat_mispredicts, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
